regfile_wb_arbiter: RTL

- Owns the single write port of the integer register file and shares it between the execute stage (EXE) and the load/store unit (LSU).
- Both requesters use a valid/ready handshake; the grant is registered onto the regfile dest_* port.
- Keeps a pending-load scoreboard: raises a read hazard for the decode stage and enforces write ordering between an outstanding load and younger EXE writes to the same register.

---
 rtl/regfile_wb_arbiter_if.sv | 47 ++++
 rtl/regfile_wb_arbiter.sv | 133 +++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus between the EXE/LSU requesters, decode and the regfile
// write-port arbiter. The master side drives requests; the slave side is the
// arbiter that owns the regfile write port.
interface regfile_wb_arbiter_if #(
  parameter int REG_COUNT  = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int XLEN       = 32
);
  // EXE writeback request
  logic                  exe_valid;
  logic                  exe_ready;
  logic [ADDR_WIDTH-1:0] exe_addr;
  logic [XLEN-1:0]       exe_data;
  // LSU load writeback request
  logic                  lsu_valid;
  logic                  lsu_ready;
  logic [ADDR_WIDTH-1:0] lsu_addr;
  logic [XLEN-1:0]       lsu_data;
  // Load issue / flush / decode hazard query
  logic                  issue_load_en;
  logic [ADDR_WIDTH-1:0] issue_load_addr;
  logic                  flush;
  logic [ADDR_WIDTH-1:0] rs1_addr;
  logic [ADDR_WIDTH-1:0] rs2_addr;
  logic                  hazard;
  logic [REG_COUNT-1:0]  pending;
  // Regfile write port
  logic                  dest_en;
  logic [ADDR_WIDTH-1:0] dest_addr;
  logic [XLEN-1:0]       dest_data;

  modport master (
    output exe_valid, exe_addr, exe_data,
    output lsu_valid, lsu_addr, lsu_data,
    output issue_load_en, issue_load_addr, flush, rs1_addr, rs2_addr,
    input  exe_ready, lsu_ready, hazard, pending,
    input  dest_en, dest_addr, dest_data
  );

  modport slave (
    input  exe_valid, exe_addr, exe_data,
    input  lsu_valid, lsu_addr, lsu_data,
    input  issue_load_en, issue_load_addr, flush, rs1_addr, rs2_addr,
    output exe_ready, lsu_ready, hazard, pending,
    output dest_en, dest_addr, dest_data
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Regfile write-port arbiter: shares the single integer regfile write port
// between EXE and LSU, tracks outstanding loads for decode hazards and keeps
// EXE writes ordered behind an older load to the same register.
module regfile_wb_arbiter #(
  parameter int REG_COUNT    = 32,
  parameter int ADDR_WIDTH   = 5,
  parameter int XLEN         = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  regfile_wb_arbiter_if.slave io_wb
);
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

  logic [REG_COUNT-1:1]  r_pending;
  logic [REG_COUNT-1:0]  w_pending;
  logic [CNT_W-1:0]      r_starve_cnt;
  logic [CNT_W-1:0]      w_starve_cnt_next;
  logic                  r_dest_en;
  logic [ADDR_WIDTH-1:0] r_dest_addr;
  logic [XLEN-1:0]       r_dest_data;

  logic w_exe_blocked;
  logic w_force_exe;
  logic w_exe_ready;
  logic w_lsu_ready;
  logic w_exe_accept;
  logic w_lsu_accept;
  logic w_wr_valid;
  logic [ADDR_WIDTH-1:0] w_wr_addr;
  logic [XLEN-1:0]       w_wr_data;

  // x0 never has an outstanding load.
  assign w_pending = {r_pending, 1'b0};

  assign w_exe_blocked = (io_wb.exe_addr != '0) && w_pending[io_wb.exe_addr];
  assign w_force_exe   = (r_starve_cnt == CNT_MAX) && io_wb.exe_valid && !w_exe_blocked;

  // Arbitration: LSU wins by default; EXE is forced once it has starved long enough.
  always_comb begin
    w_exe_ready = 1'b0;
    w_lsu_ready = 1'b0;
    if (w_force_exe) begin
      w_exe_ready = 1'b1;
    end else begin
      w_lsu_ready = io_wb.lsu_valid;
      w_exe_ready = io_wb.exe_valid && !w_exe_blocked && !io_wb.lsu_valid;
    end
  end

  assign w_exe_accept = io_wb.exe_valid && w_exe_ready;
  assign w_lsu_accept = io_wb.lsu_valid && w_lsu_ready;

  // Select the winning write; the two accepts are mutually exclusive.
  always_comb begin
    w_wr_valid = 1'b0;
    w_wr_addr  = io_wb.exe_addr;
    w_wr_data  = io_wb.exe_data;
    if (w_lsu_accept) begin
      w_wr_valid = io_wb.lsu_addr != '0;
      w_wr_addr  = io_wb.lsu_addr;
      w_wr_data  = io_wb.lsu_data;
    end else if (w_exe_accept) begin
      w_wr_valid = io_wb.exe_addr != '0;
    end
  end

  // Starvation counter next state: counts EXE losses to LSU, saturating.
  always_comb begin
    w_starve_cnt_next = r_starve_cnt;
    if (io_wb.flush || w_exe_accept || !io_wb.exe_valid) begin
      w_starve_cnt_next = '0;
    end else if (!w_exe_blocked && w_lsu_accept && (r_starve_cnt != CNT_MAX)) begin
      w_starve_cnt_next = r_starve_cnt + CNT_W'(1);
    end
  end

  // Starvation counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_starve_cnt <= '0;
    end else begin
      r_starve_cnt <= w_starve_cnt_next;
    end
  end

  // Registered regfile write port; address/data only move with a real write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dest_en   <= 1'b0;
      r_dest_addr <= '0;
      r_dest_data <= '0;
    end else begin
      r_dest_en <= w_wr_valid;
      if (w_wr_valid) begin
        r_dest_addr <= w_wr_addr;
        r_dest_data <= w_wr_data;
      end
    end
  end

  // Pending-load scoreboard, one flop per architectural register above x0.
  for (genvar gi = 1; gi < REG_COUNT; gi++) begin : g_pending
    logic w_set;
    logic w_clr;
    assign w_set = io_wb.issue_load_en && (io_wb.issue_load_addr == ADDR_WIDTH'(gi));
    assign w_clr = w_lsu_accept && (io_wb.lsu_addr == ADDR_WIDTH'(gi));

    // Flush kills everything; a newly issued load outranks a same-cycle completion.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_pending[gi] <= 1'b0;
      end else if (io_wb.flush) begin
        r_pending[gi] <= 1'b0;
      end else if (w_set) begin
        r_pending[gi] <= 1'b1;
      end else if (w_clr) begin
        r_pending[gi] <= 1'b0;
      end
    end
  end

  assign io_wb.exe_ready = w_exe_ready;
  assign io_wb.lsu_ready = w_lsu_ready;
  assign io_wb.pending   = w_pending;
  assign io_wb.hazard    = ((io_wb.rs1_addr != '0) && w_pending[io_wb.rs1_addr]) ||
                           ((io_wb.rs2_addr != '0) && w_pending[io_wb.rs2_addr]);
  assign io_wb.dest_en   = r_dest_en;
  assign io_wb.dest_addr = r_dest_addr;
  assign io_wb.dest_data = r_dest_data;
endmodule
